// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner:
// segment bit positions and the hex glyph table.
package display_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [6:0] glyph_t;

  // Active-high glyphs, bit order g..a
  localparam glyph_t HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_seg_decoder.sv
// Hex nibble to active-high 7-segment glyph.
// Purely combinational table lookup.
module hex_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nib];

endmodule

// File: rtl/display_7seg_scan.sv
// Time-multiplexed hex display scanner with shadow
// registers, leading-zero blanking and PWM brightness.
module display_7seg_scan
  import display_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  LOAD,
  input  logic                  BLANK_LZ,
  input  logic [2:0]            BRIGHT,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     SEG_SEL
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned STEP = PRESCALE / 8;

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

  localparam logic [PW-1:0] CNT_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_q;
  logic [2:0]            bright_q;
  logic [7:0]            seg_q;
  logic [DIGITS-1:0]     sel_q;

  logic                  wrap;
  logic [DIGITS-1:0]     blank;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [31:0]           lim;
  logic                  on;
  logic [6:0]            glyph;
  logic [7:0]            seg_d;
  logic [DIGITS-1:0]     sel_d;

  assign wrap = (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt      <= '0;
      idx      <= '0;
      bright_q <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (cnt == '0) begin
        bright_q <= BRIGHT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      data_q <= '0;
      dp_q   <= '0;
    end else if (LOAD) begin
      data_q <= DATA;
      dp_q   <= DP;
    end
  end

  // Zero run from the most significant digit downwards
  always_comb begin
    logic zacc;
    zacc  = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zacc     = zacc && (data_q[4*i +: 4] == 4'h0);
      blank[i] = BLANK_LZ && zacc && !dp_q[i] && (i != 0);
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = data_q[4*i +: 4];
        cur_dp    = dp_q[i];
        cur_blank = blank[i];
      end
    end
  end

  hex_seg_decoder u_dec (
    .nib (cur_nib),
    .seg (glyph)
  );

  // Count 0 is the dead cycle between slots
  always_comb begin
    lim = (32'(bright_q) + 32'd1) * STEP;
    on  = (cnt != '0)
       && (32'(cnt) < lim)
       && !cur_blank;
  end

  always_comb begin
    seg_d = '0;
    sel_d = '0;
    if (on) begin
      seg_d[SEG_G:SEG_A] = glyph;
      seg_d[SEG_DP]      = cur_dp;
      for (int i = 0; i < DIGITS; i++) begin
        sel_d[i] = (idx == IW'(i));
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      seg_q <= '0;
      sel_q <= '0;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign SEG     = seg_q ^ {8{SEG_INV}};
  assign SEG_SEL = sel_q ^ {DIGITS{SEL_INV}};

endmodule

// File: tb/tb_display_7seg_scan.sv
// Scoreboard bench: stimulus queues expected select runs,
// a negedge monitor measures runs and compares them.
module tb_display_7seg_scan;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
    int         len;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic [15:0] DATA = 16'h0;
  logic [3:0]  DP = 4'h0;
  logic        LOAD = 1'b0;
  logic        BLANK_LZ = 1'b0;
  logic [2:0]  BRIGHT = 3'd7;
  logic [7:0]  SEG;
  logic [3:0]  SEG_SEL;

  logic [31:0] data8 = 32'hFEDCBA98;
  logic [7:0]  dp8 = 8'h01;
  logic [7:0]  seg8;
  logic [7:0]  sel8;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  bit   loaded8 = 1'b0;

  logic [3:0]  run_sel = '0;
  logic [7:0]  run_seg = '0;
  int          run_len = 0;

  always #5 CLK = ~CLK;

  display_7seg_scan #(
    .DIGITS(4), .PRESCALE(16),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .DATA(DATA), .DP(DP),
    .LOAD(LOAD), .BLANK_LZ(BLANK_LZ), .BRIGHT(BRIGHT),
    .SEG(SEG), .SEG_SEL(SEG_SEL)
  );

  display_7seg_scan #(
    .DIGITS(8), .PRESCALE(16),
    .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
  ) dut8 (
    .CLK(CLK), .RSTN(RSTN), .DATA(data8), .DP(dp8),
    .LOAD(LOAD), .BLANK_LZ(BLANK_LZ), .BRIGHT(BRIGHT),
    .SEG(seg8), .SEG_SEL(sel8)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  task automatic end_run();
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL run_extra: sel=%h seg=%h len=%0d required none",
               run_sel, run_seg, run_len);
    end else begin
      e = q.pop_front();
      if (e.sel !== run_sel || e.seg !== run_seg || e.len != run_len) begin
        miscompares++;
        $display("FAIL run: sel=%h seg=%h len=%0d required sel=%h seg=%h len=%0d",
                 run_sel, run_seg, run_len, e.sel, e.seg, e.len);
      end
    end
  endtask

  always @(negedge CLK) begin
    logic [3:0] sh;
    logic [7:0] gh;
    logic [7:0] e8;
    if (mon_en) begin
      sh = ~SEG_SEL;
      gh = ~SEG;
      vectors++;
      if (!$onehot0(sh) || (sh == 4'h0 && gh != 8'h0)) begin
        miscompares++;
        $display("FAIL invariant4: sel=%h seg=%h", sh, gh);
      end
      vectors++;
      if (!$onehot0(sel8) || (sel8 == 8'h0 && seg8 != 8'h0)) begin
        miscompares++;
        $display("FAIL invariant8: sel=%h seg=%h", sel8, seg8);
      end
      for (int i = 0; i < 8; i++) begin
        if (sel8[i]) begin
          e8 = loaded8 ? {dp8[i], glyph(data8[4*i +: 4])} : 8'h3F;
          vectors++;
          if (seg8 !== e8) begin
            miscompares++;
            $display("FAIL seg8: digit=%0d seg=%h required %h", i, seg8, e8);
          end
        end
      end
      if (run_len > 0 && (sh != run_sel || gh != run_seg)) begin
        end_run();
        run_len = 0;
      end
      if (sh != 4'h0) begin
        if (run_len == 0) begin
          run_sel = sh;
          run_seg = gh;
        end
        run_len++;
      end
    end
  end

  task automatic push(input int d, input logic [7:0] s, input int len);
    exp_t e;
    e.sel = 4'(1 << d);
    e.seg = s;
    e.len = len;
    q.push_back(e);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    #1;
    vectors++;
    if (SEG !== 8'hFF || SEG_SEL !== 4'hF) begin
      miscompares++;
      $display("FAIL reset4: seg=%h sel=%h required ff f", SEG, SEG_SEL);
    end
    vectors++;
    if (seg8 !== 8'h00 || sel8 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset8: seg=%h sel=%h required 00 00", seg8, sel8);
    end
    loaded8 = 1'b0;
    mon_en  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: pending=%0d required 0", q.size());
      q.delete();
    end
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  // One 16-cycle slot; len 0 means the digit stays dark
  task automatic run_slot(input int d, input logic [7:0] s,
                          input int len, input bit ld, input int nb);
    LOAD = ld;
    @(posedge CLK);
    #1;
    LOAD = 1'b0;
    if (ld) loaded8 = 1'b1;
    if (len > 0) push(d, s, len);
    repeat (4) @(posedge CLK);
    #1;
    if (nb >= 0) BRIGHT = 3'(nb);
    repeat (11) @(posedge CLK);
    #1;
  endtask

  initial begin
    DATA = 16'h12AF;
    #3;
    do_reset();

    run_slot(0, 8'h71, 15, 1, -1);
    run_slot(1, 8'h77, 15, 0, -1);
    run_slot(2, 8'h5B, 15, 0, -1);
    run_slot(3, 8'h06, 15, 0, -1);
    DATA = 16'h5555;
    run_slot(0, 8'h71, 15, 0, -1);
    run_slot(1, 8'h77, 15, 0, -1);
    run_slot(2, 8'h5B, 15, 0, -1);
    run_slot(3, 8'h06, 15, 0, -1);
    DATA = 16'h0021;
    DP   = 4'b0001;
    run_slot(0, 8'h86, 15, 1, -1);
    run_slot(1, 8'h5B, 15, 0, -1);
    run_slot(2, 8'h3F, 15, 0, -1);
    run_slot(3, 8'h3F, 15, 0, -1);

    BRIGHT = 3'd0;
    run_slot(0, 8'h86, 1, 0, -1);
    run_slot(1, 8'h5B, 1, 0, -1);
    run_slot(2, 8'h3F, 1, 0, -1);
    run_slot(3, 8'h3F, 1, 0, -1);
    run_slot(0, 8'h86, 1, 0, 3);
    run_slot(1, 8'h5B, 7, 0, -1);
    run_slot(2, 8'h3F, 7, 0, 7);
    run_slot(3, 8'h3F, 15, 0, -1);

    BLANK_LZ = 1'b1;
    DATA = 16'h0005;
    DP   = 4'b0000;
    run_slot(0, 8'h6D, 15, 1, -1);
    run_slot(1, 8'h00, 0, 0, -1);
    run_slot(2, 8'h00, 0, 0, -1);
    run_slot(3, 8'h00, 0, 0, -1);
    DP = 4'b0100;
    run_slot(0, 8'h6D, 15, 1, -1);
    run_slot(1, 8'h00, 0, 0, -1);
    run_slot(2, 8'hBF, 15, 0, -1);
    run_slot(3, 8'h00, 0, 0, -1);
    DATA = 16'h0000;
    DP   = 4'b0000;
    run_slot(0, 8'h3F, 15, 1, -1);
    run_slot(1, 8'h00, 0, 0, -1);
    run_slot(2, 8'h00, 0, 0, -1);
    run_slot(3, 8'h00, 0, 0, -1);

    BLANK_LZ = 1'b0;
    DATA = 16'h12AF;
    run_slot(0, 8'h71, 15, 1, -1);
    @(posedge CLK);
    #1;
    push(1, 8'h77, 5);
    repeat (6) @(posedge CLK);
    #1;
    do_reset();
    run_slot(0, 8'h3F, 15, 0, -1);
    run_slot(1, 8'h3F, 15, 0, -1);
    run_slot(2, 8'h3F, 15, 0, -1);
    run_slot(3, 8'h3F, 15, 0, -1);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: pending=%0d required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
